// File: rtl/stm1_frame_aligner_pkg.sv
// Shared constants and types for the STM-1 receive framing path.
// Holds frame geometry, framing bytes, alignment thresholds and the
// alignment state encoding used by the aligner and downstream stages.
package stm1_frame_aligner_pkg;

  localparam int unsigned STM1_LENGTH      = 270;
  localparam int unsigned STM1_WIDTH       = 9;
  localparam int unsigned STM1_FRAME_BYTES = STM1_LENGTH * STM1_WIDTH;

  localparam logic [7:0] STM1_A1_BYTE = 8'hF6;
  localparam logic [7:0] STM1_A2_BYTE = 8'h28;
  localparam logic [47:0] STM1_FRAME_WORD = {{3{STM1_A1_BYTE}}, {3{STM1_A2_BYTE}}};

  localparam int unsigned HIT_FRAMES  = 2;
  localparam int unsigned MISS_FRAMES = 4;
  localparam int unsigned LOF_FRAMES  = 24;

  localparam int unsigned HIT_W   = $clog2(HIT_FRAMES + 1);
  localparam int unsigned MISS_W  = $clog2(MISS_FRAMES + 1);
  localparam int unsigned LOF_W   = $clog2(LOF_FRAMES + 1);
  localparam int unsigned ROW_W   = 4;
  localparam int unsigned COL_W   = 9;
  localparam int unsigned TIMER_W = 12;

  // Column of the last A2 byte in row 0.
  localparam int unsigned CHECK_COL = 5;

  typedef enum logic [1:0] {
    ALIGN_HUNT,
    ALIGN_PRESYNC,
    ALIGN_SYNC
  } align_state_t;

endpackage

// File: rtl/stm1_frame_aligner_pos_counter.sv
// stm1_pos_counter: row/column position counter for a LENGTH x WIDTH frame.
// row_o/col_o give the position of the next byte to arrive. load_i sets that
// position directly (and wins over en_i); en_i advances it by one byte,
// wrapping col at LENGTH-1 and row at WIDTH-1.
// Ports: clk, rst (sync, active-high), en_i, load_i, load_row_i, load_col_i,
//        row_o, col_o.
module stm1_pos_counter
  import stm1_frame_aligner_pkg::*;
#(
  parameter int unsigned LENGTH = STM1_LENGTH,
  parameter int unsigned WIDTH  = STM1_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [ROW_W-1:0] load_row_i,
  input  logic [COL_W-1:0] load_col_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  // Next position: load, or step with col/row wrap.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (load_i) begin
      row_d = load_row_i;
      col_d = load_col_i;
    end else if (en_i) begin
      if (col_q == COL_W'(LENGTH - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(WIDTH - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/stm1_frame_aligner.sv
// stm1_frame_aligner: hunts the A1A1A1A2A2A2 framing word in a raw STM-1
// byte stream, locks to the frame and tags each byte with row/col/SOF.
// Reports in-frame, out-of-frame and loss-of-frame status.
// Ports: clk, rst (sync, active-high), in_valid, in_data[7:0],
//        out_valid, out_data[7:0], out_sof, out_row[3:0], out_col[8:0],
//        in_frame, oof, lof. All outputs registered, 1 clk latency.
module stm1_frame_aligner
  import stm1_frame_aligner_pkg::*;
#(
  parameter int unsigned LENGTH = STM1_LENGTH,
  parameter int unsigned WIDTH  = STM1_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_sof,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic             in_frame,
  output logic             oof,
  output logic             lof
);

  localparam int unsigned FRAME_BYTES = LENGTH * WIDTH;

  align_state_t      state_q, state_d;
  logic [39:0]       hist_q;
  logic [47:0]       window;
  logic [HIT_W-1:0]  hit_q, hit_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [LOF_W-1:0]  lof_cnt_q, lof_cnt_d;
  logic [LOF_W-1:0]  sync_cnt_q, sync_cnt_d;
  logic              lof_d;
  logic [ROW_W-1:0]  pos_row;
  logic [COL_W-1:0]  pos_col;
  logic              match, check_pt, timer_wrap, sync_d, pos_load;

  // Last five bytes plus the current one form the 6-byte match window.
  assign window     = {hist_q, in_data};
  assign match      = (window == STM1_FRAME_WORD);
  assign check_pt   = (pos_row == '0) && (pos_col == COL_W'(CHECK_COL));
  assign timer_wrap = (timer_q == TIMER_W'(FRAME_BYTES - 1));
  assign timer_d    = timer_wrap ? '0 : timer_q + TIMER_W'(1);
  assign sync_d     = (state_d == ALIGN_SYNC);

  // A hunt match makes the current byte the last A2, so the next is col+1.
  assign pos_load = in_valid && (state_q == ALIGN_HUNT) && match;

  stm1_pos_counter #(
    .LENGTH (LENGTH),
    .WIDTH  (WIDTH)
  ) u_pos (
    .clk        (clk),
    .rst        (rst),
    .en_i       (in_valid),
    .load_i     (pos_load),
    .load_row_i (ROW_W'(0)),
    .load_col_i (COL_W'(CHECK_COL + 1)),
    .row_o      (pos_row),
    .col_o      (pos_col)
  );

  // Alignment next-state and hit/miss counters.
  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    case (state_q)
      ALIGN_HUNT: begin
        if (match) begin
          state_d = ALIGN_PRESYNC;
          hit_d   = HIT_W'(1);
          miss_d  = '0;
        end
      end
      ALIGN_PRESYNC: begin
        if (check_pt) begin
          if (match) begin
            if (hit_q != HIT_W'(HIT_FRAMES)) hit_d = hit_q + HIT_W'(1);
            if (hit_d == HIT_W'(HIT_FRAMES)) begin
              state_d = ALIGN_SYNC;
              miss_d  = '0;
            end
          end else begin
            state_d = ALIGN_HUNT;
            hit_d   = '0;
          end
        end
      end
      ALIGN_SYNC: begin
        if (check_pt) begin
          if (match) begin
            miss_d = '0;
          end else begin
            if (miss_q != MISS_W'(MISS_FRAMES)) miss_d = miss_q + MISS_W'(1);
            if (miss_d == MISS_W'(MISS_FRAMES)) begin
              state_d = ALIGN_HUNT;
              hit_d   = '0;
              miss_d  = '0;
            end
          end
        end
      end
      default: state_d = ALIGN_HUNT;
    endcase
  end

  // LOF: count frame periods out of frame to set, in frame to clear.
  always_comb begin
    lof_cnt_d  = lof_cnt_q;
    sync_cnt_d = sync_cnt_q;
    lof_d      = lof;
    if (sync_d && (state_q != ALIGN_SYNC)) begin
      lof_cnt_d = '0;
    end else if (oof && timer_wrap && (lof_cnt_q != LOF_W'(LOF_FRAMES))) begin
      lof_cnt_d = lof_cnt_q + LOF_W'(1);
      if (lof_cnt_d == LOF_W'(LOF_FRAMES)) lof_d = 1'b1;
    end
    if (state_q != ALIGN_SYNC) begin
      sync_cnt_d = '0;
    end else if (timer_wrap && (sync_cnt_q != LOF_W'(LOF_FRAMES))) begin
      sync_cnt_d = sync_cnt_q + LOF_W'(1);
      if (sync_cnt_d == LOF_W'(LOF_FRAMES)) lof_d = 1'b0;
    end
  end

  // State, counters and output registers; everything holds on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ALIGN_HUNT;
      hist_q     <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      timer_q    <= '0;
      lof_cnt_q  <= '0;
      sync_cnt_q <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      in_frame   <= 1'b0;
      oof        <= 1'b1;
      lof        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        state_q    <= state_d;
        hist_q     <= window[39:0];
        hit_q      <= hit_d;
        miss_q     <= miss_d;
        timer_q    <= timer_d;
        lof_cnt_q  <= lof_cnt_d;
        sync_cnt_q <= sync_cnt_d;
        lof        <= lof_d;
        out_data   <= in_data;
        out_sof    <= sync_d && (pos_row == '0) && (pos_col == '0);
        out_row    <= sync_d ? pos_row : '0;
        out_col    <= sync_d ? pos_col : '0;
        in_frame   <= sync_d;
        oof        <= !sync_d;
      end
    end
  end

endmodule

// File: tb/tb_stm1_frame_aligner.sv
// Directed bench for stm1_frame_aligner, run on a 30x9 frame so that the
// long LOF sequences stay short. Every output byte is compared against its
// position derived from the byte index within the transmitted frame.
module tb_stm1_frame_aligner;

  localparam int LEN = 30;
  localparam int ROWS = 9;
  localparam int FB = LEN * ROWS;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sof;
  logic [3:0] out_row;
  logic [8:0] out_col;
  logic       in_frame;
  logic       oof;
  logic       lof;
  logic [25:0] obs;

  int errors;
  int checks;
  int cur_f;
  int cur_k;

  stm1_frame_aligner #(
    .LENGTH (LEN),
    .WIDTH  (ROWS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_row   (out_row),
    .out_col   (out_col),
    .in_frame  (in_frame),
    .oof       (oof),
    .lof       (lof)
  );

  always #5 clk = ~clk;

  assign obs = {out_valid, in_frame, oof, out_sof, out_row, out_col, out_data, lof};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s frame=%0d byte=%0d got=%h exp=%h", tag, cur_f, cur_k, got, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input int k, input int mode);
    logic [7:0] v;
    v = 8'((k * 13 + 7) & 255);
    if (v == 8'hF6 || v == 8'h28) v = 8'h11;
    if (mode != 2) begin
      if (k < 3) v = 8'hF6;
      else if (k < 6) v = (mode == 1 && k == 5) ? 8'h29 : 8'h28;
    end
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    @(posedge clk);
    #1;
    check_eq("gap_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst      = 1'b1;
    in_valid = 1'b1;
    repeat (2) begin
      in_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    // valid, in_frame, oof, sof, row, col, data, lof
    check_eq(tag, 32'(obs), 32'({1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 9'd0, 8'd0, 1'b0}));
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  // mode: 0 clean, 1 third A2 corrupted, 2 no framing word.
  // Bytes k >= chk_from are checked; [lo,hi) expects lock, the rest not.
  // Expected lof is exp_lof before byte lof_at and inverted from it on.
  task automatic send_frame(input int mode, input int chk_from, input int lo, input int hi,
                            input bit exp_lof, input int lof_at, input bit gaps, input int n);
    logic [7:0]  b;
    logic        lofx;
    logic [25:0] exp;
    int          ng;
    cur_f++;
    for (int k = 0; k < n; k++) begin
      cur_k = k;
      b = frame_byte(k, mode);
      if (gaps) begin
        ng = 0;
        while (ng < 3 && $urandom_range(0, 1) == 1) begin
          idle_cycle();
          ng++;
        end
      end
      send_byte(b);
      lofx = (k >= lof_at) ? !exp_lof : exp_lof;
      if (k >= chk_from) begin
        if (k >= lo && k < hi)
          exp = {1'b1, 1'b1, 1'b0, (k == 0), 4'(k / LEN), 9'(k % LEN), b, lofx};
        else
          exp = {1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 9'd0, b, lofx};
        check_eq((k >= lo && k < hi) ? "locked" : "unlocked", 32'(obs), 32'(exp));
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog frame=%0d byte=%0d", cur_f, cur_k);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0;
    errors = 0; checks = 0; cur_f = 0; cur_k = 0;
    do_reset("reset");

    // Acquire: PRESYNC after frame 1, SYNC at frame 2 col 5, full tags after.
    send_frame(0, 0, 0, 0, 0, FB, 0, FB);
    send_frame(0, 0, 5, FB, 0, FB, 0, FB);
    send_frame(0, 0, 0, FB, 0, FB, 0, FB);

    // Three bad frames then a good one keep lock and clear the miss count.
    repeat (3) send_frame(1, 0, 0, FB, 0, FB, 0, FB);
    send_frame(0, 0, 0, FB, 0, FB, 0, FB);
    repeat (3) send_frame(1, 0, 0, FB, 0, FB, 0, FB);
    // Fourth consecutive bad frame drops lock right after its check point.
    send_frame(1, 0, 0, 5, 0, FB, 0, FB);
    // Reacquire.
    send_frame(0, 0, 0, 0, 0, FB, 0, FB);
    send_frame(0, 0, 5, FB, 0, FB, 0, FB);

    // One-byte phase slip: the extra byte is tagged as the next frame start.
    cur_k = -1;
    send_byte(8'h00);
    check_eq("slip_byte", 32'(obs), 32'({1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 9'd0, 8'h00, 1'b0}));
    repeat (3) begin
      send_frame(0, FB, 0, 0, 0, FB, 0, FB);
      check_eq("slip_hold", 32'(in_frame), 32'd1);
    end
    // Fourth miss at shifted col 4, immediate rehunt on the real last A2.
    send_frame(0, 4, 0, 0, 0, FB, 0, FB);
    send_frame(0, 0, 5, FB, 0, FB, 0, FB);

    // Random idle gaps must not disturb tagging.
    repeat (5) send_frame(0, 0, 0, FB, 0, FB, 1, FB);

    // Reset in the middle of a locked frame.
    send_frame(0, 0, 0, FB, 0, FB, 0, 100);
    do_reset("midframe_reset");

    // No framing word: lof rises on the 24th timer wrap.
    for (int z = 0; z < 24; z++)
      send_frame(2, 0, 0, 0, 0, (z == 23) ? FB - 1 : FB, 0, FB);
    // Clean frames: lock after 2, lof clears after 24 frame periods in SYNC.
    send_frame(0, 0, 0, 0, 1, FB, 0, FB);
    send_frame(0, 0, 5, FB, 1, FB, 0, FB);
    for (int z = 0; z < 22; z++)
      send_frame(0, 0, 0, FB, 1, FB, 0, FB);
    send_frame(0, 0, 0, FB, 1, FB - 1, 0, FB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
